// File: rtl/sim_done_gen.sv
// sim_done_gen: run controller for emulated-link simulations.
// Walks IDLE -> WARMUP -> RUN -> DONE on emulator ticks. It counts qualified
// checker errors during RUN and raises a sticky sim_done.
// Optional feature: define SIM_DONE_ON_ERR_EN to end the run early, flagged as
// aborted, once err_count reaches ERR_MAX.
module sim_done_gen #(
  parameter int WARM_W  = 16,
  parameter int RUN_W   = 32,
  parameter int ERR_W   = 16,
  parameter int ERR_MAX = 1
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              start,
  input  logic [WARM_W-1:0] warmup_cycles,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              tick,
  input  logic              bit_err,
  input  logic              abort,
  output logic [1:0]        state,
  output logic [RUN_W-1:0]  tick_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              aborted,
  output logic              sim_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Run configuration, captured once when start is accepted.
  typedef struct packed {
    logic [WARM_W-1:0] warm;
    logic [RUN_W-1:0]  run;
  } cfg_t;

`ifdef SIM_DONE_ON_ERR_EN
  localparam bit ERR_STOP_EN = 1'b1;
`else
  localparam bit ERR_STOP_EN = 1'b0;
`endif
  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(ERR_MAX);

  state_t            state_q, state_n;
  cfg_t              cfg_q, cfg_n;
  logic [WARM_W-1:0] warm_q, warm_n;
  logic [RUN_W-1:0]  tick_n;
  logic [ERR_W-1:0]  err_n;
  logic              abort_n;
  logic              last_tick;
  logic              err_hit;

  // Next-state and counter updates. The natural final tick wins over abort
  // or an error stop, so a run that actually finished is never flagged aborted.
  always_comb begin
    state_n   = state_q;
    cfg_n     = cfg_q;
    warm_n    = warm_q;
    tick_n    = tick_count;
    err_n     = err_count;
    abort_n   = aborted;
    last_tick = 1'b0;
    err_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_n   = '{warm: warmup_cycles, run: run_cycles};
          warm_n  = '0;
          tick_n  = '0;
          err_n   = '0;
          abort_n = 1'b0;
          state_n = (warmup_cycles != '0) ? S_WARMUP : S_RUN;
        end
      end
      S_WARMUP: begin
        if (tick) begin
          warm_n = warm_q + 1'b1;
          if (warm_q == cfg_q.warm - 1'b1) state_n = S_RUN;
        end
        if (abort) begin
          state_n = S_DONE;
          abort_n = 1'b1;
        end
      end
      S_RUN: begin
        // A zero-length run finishes immediately, which counts as completion.
        if (cfg_q.run == '0) begin
          state_n = S_DONE;
        end else begin
          if (tick) begin
            tick_n    = tick_count + 1'b1;
            last_tick = (tick_count == cfg_q.run - 1'b1);
            if (bit_err && (err_count != '1)) begin
              err_n   = err_count + 1'b1;
              err_hit = (err_n == ERR_LIM);
            end
          end
          if (last_tick) begin
            state_n = S_DONE;
          end else if (abort || (ERR_STOP_EN && err_hit)) begin
            state_n = S_DONE;
            abort_n = 1'b1;
          end
        end
      end
      default: ;  // S_DONE: frozen until reset
    endcase
  end

  // State, configuration and output registers; sim_done is sticky.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      warm_q     <= '0;
      tick_count <= '0;
      err_count  <= '0;
      aborted    <= 1'b0;
      sim_done   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cfg_q      <= cfg_n;
      warm_q     <= warm_n;
      tick_count <= tick_n;
      err_count  <= err_n;
      aborted    <= abort_n;
      sim_done   <= sim_done | (state_n == S_DONE);
    end
  end

  assign state = state_q;

endmodule
